// File: rtl/flash_bank_arb_if.sv
// flash_bank_arb_if: host, controller and flash macro signals of the bank arbiter
interface flash_bank_arb_if #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 16
);
  logic                 h_req_i;
  logic [AddrWidth-1:0] h_addr_i;
  logic                 h_gnt_o;
  logic                 h_rvalid_o;
  logic [DataWidth-1:0] h_rdata_o;
  logic                 h_err_o;
  logic                 c_req_i;
  logic [1:0]           c_op_i;
  logic [AddrWidth-1:0] c_addr_i;
  logic [DataWidth-1:0] c_wdata_i;
  logic                 c_gnt_o;
  logic                 c_done_o;
  logic [DataWidth-1:0] c_rdata_o;
  logic                 c_err_o;
  logic                 f_req_o;
  logic [1:0]           f_op_o;
  logic [AddrWidth-1:0] f_addr_o;
  logic [DataWidth-1:0] f_wdata_o;
  logic                 f_ack_i;
  logic [DataWidth-1:0] f_rdata_i;
  logic                 f_err_i;
  modport slave (
    input  h_req_i, h_addr_i, c_req_i, c_op_i, c_addr_i, c_wdata_i, f_ack_i, f_rdata_i, f_err_i,
    output h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o, c_gnt_o, c_done_o, c_rdata_o, c_err_o,
           f_req_o, f_op_o, f_addr_o, f_wdata_o
  );
  modport master (
    output h_req_i, h_addr_i, c_req_i, c_op_i, c_addr_i, c_wdata_i, f_ack_i, f_rdata_i, f_err_i,
    input  h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o, c_gnt_o, c_done_o, c_rdata_o, c_err_o,
           f_req_o, f_op_o, f_addr_o, f_wdata_o
  );
endinterface

// File: rtl/flash_bank_arb.sv
// flash_bank_arb: round-robin host/controller arbiter for a flash macro, one operation in flight
module flash_bank_arb #(
  parameter int DataWidth     = 64,
  parameter int AddrWidth     = 16,
  parameter int TimeoutCycles = 255
) (
  input logic            clk_i,
  input logic            rst_i,
  flash_bank_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t               state, state_nxt;
  logic                 h_gnt, c_gnt, timeout, resp, last_c, owner_c, f_req, err_q;
  logic [1:0]           op_q, op_sel;
  logic [AddrWidth-1:0] addr_q, addr_sel, addr_nxt;
  logic [DataWidth-1:0] wdata_q, rdata_q;
  logic [7:0]           tcnt;
  always_comb begin
    h_gnt     = state == IDLE && !rst_i && bus.h_req_i && (!bus.c_req_i || last_c);
    c_gnt     = state == IDLE && !rst_i && bus.c_req_i && !h_gnt;
    timeout   = tcnt == 8'(TimeoutCycles - 1);
    op_sel    = h_gnt ? 2'b00 : bus.c_op_i;
    addr_sel  = h_gnt ? bus.h_addr_i : bus.c_addr_i;
    addr_nxt  = op_sel == 2'b11 ? {addr_sel[AddrWidth-1], {(AddrWidth-1){1'b0}}} :
                op_sel == 2'b10 ? {addr_sel[AddrWidth-1:7], 7'b0} : addr_sel;
    state_nxt = state == IDLE ? ((h_gnt || c_gnt) ? BUSY : IDLE) :
                state == BUSY ? ((bus.f_ack_i || timeout) ? RESP : BUSY) : IDLE;
    resp      = state == RESP;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      last_c  <= 1'b1;
      owner_c <= 1'b0;
      f_req   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= state_nxt;
      if (h_gnt || c_gnt) begin
        last_c  <= c_gnt;
        owner_c <= c_gnt;
        f_req   <= 1'b1;
        op_q    <= op_sel;
        addr_q  <= addr_nxt;
        wdata_q <= c_gnt ? bus.c_wdata_i : '0;
        tcnt    <= '0;
      end
      // an ack arriving on the timeout cycle still completes normally
      if (state == BUSY) begin
        if (bus.f_ack_i) begin
          rdata_q <= op_q == 2'b00 ? bus.f_rdata_i : '0;
          err_q   <= bus.f_err_i;
          f_req   <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          f_req   <= 1'b0;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
    end
  end
  assign bus.h_gnt_o    = h_gnt;
  assign bus.c_gnt_o    = c_gnt;
  assign bus.h_rvalid_o = resp && !owner_c;
  assign bus.h_rdata_o  = (resp && !owner_c) ? rdata_q : '0;
  assign bus.h_err_o    = resp && !owner_c && err_q;
  assign bus.c_done_o   = resp && owner_c;
  assign bus.c_rdata_o  = (resp && owner_c) ? rdata_q : '0;
  assign bus.c_err_o    = resp && owner_c && err_q;
  assign bus.f_req_o    = f_req;
  assign bus.f_op_o     = op_q;
  assign bus.f_addr_o   = addr_q;
  assign bus.f_wdata_o  = wdata_q;
endmodule

// File: tb/tb_flash_bank_arb.sv
// tb_flash_bank_arb: directed stimulus with a response scoreboard checked by an independent monitor
module tb_flash_bank_arb;
  typedef struct packed {logic ctrl; logic [63:0] rdata; logic err;} resp_t;
  logic  clk, rst;
  int    compared, failed;
  resp_t q[$];
  resp_t e;
  flash_bank_arb_if #(.DataWidth(64), .AddrWidth(16)) bus();
  flash_bank_arb #(.DataWidth(64), .AddrWidth(16), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.h_rvalid_o || bus.c_done_o) begin
        if (q.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_resp: got h_rvalid=%0b c_done=%0b expected none", bus.h_rvalid_o, bus.c_done_o);
        end else begin
          e = q.pop_front();
          chk("resp_both", bus.h_rvalid_o & bus.c_done_o, 0);
          chk("resp_owner", bus.c_done_o, e.ctrl);
          chk("resp_rdata", e.ctrl ? bus.c_rdata_o : bus.h_rdata_o, e.rdata);
          chk("resp_err", e.ctrl ? bus.c_err_o : bus.h_err_o, e.err);
          chk("resp_other_zero", e.ctrl ? {bus.h_rdata_o, bus.h_err_o} : {bus.c_rdata_o, bus.c_err_o}, 0);
        end
      end else if (|{bus.h_rdata_o, bus.h_err_o, bus.c_rdata_o, bus.c_err_o}) begin
        compared++;
        failed++;
        $display("FAIL idle_data: got nonzero response data expected 0");
      end
    end
  end
  // called at posedge+1 in IDLE; ack_at = BUSY cycle carrying f_ack_i, 0 = let it time out
  task automatic op_run(input bit ctrl, input logic [1:0] op, input logic [15:0] addr, input logic [63:0] wd,
                        input int ack_at, input logic [63:0] frd, input logic ferr, input logic [15:0] exp_addr);
    int n;
    if (ctrl) begin
      bus.c_req_i = 1; bus.c_op_i = op; bus.c_addr_i = addr; bus.c_wdata_i = wd;
    end else begin
      bus.h_req_i = 1; bus.h_addr_i = addr;
    end
    #1;
    chk("h_gnt", bus.h_gnt_o, !ctrl);
    chk("c_gnt", bus.c_gnt_o, ctrl);
    q.push_back('{ctrl, (ack_at > 0 && op == 2'b00) ? frd : 64'h0, ack_at > 0 ? ferr : 1'b1});
    @(posedge clk) #1;
    bus.h_req_i = 0; bus.c_req_i = 0;
    chk("f_req", bus.f_req_o, 1);
    chk("f_op", bus.f_op_o, op);
    chk("f_addr", bus.f_addr_o, exp_addr);
    chk("f_wdata", bus.f_wdata_o, ctrl ? wd : 64'h0);
    if (ack_at > 0) begin
      for (int k = 1; k <= ack_at; k++) begin
        if (k == ack_at) begin
          bus.f_ack_i = 1; bus.f_rdata_i = frd; bus.f_err_i = ferr;
        end
        chk("f_req_hold", bus.f_req_o, 1);
        @(posedge clk) #1;
        bus.f_ack_i = 0; bus.f_rdata_i = 0; bus.f_err_i = 0;
      end
      chk("resp_pulse", ctrl ? bus.c_done_o : bus.h_rvalid_o, 1);
      @(posedge clk) #1;
      chk("resp_single", bus.c_done_o | bus.h_rvalid_o, 0);
    end else begin
      n = 0;
      repeat (4) begin
        if (bus.f_req_o) n++;
        @(posedge clk) #1;
      end
      chk("timeout_cycles", n, 4);
      chk("timeout_drop", bus.f_req_o, 0);
      chk("timeout_pulse", ctrl ? bus.c_done_o : bus.h_rvalid_o, 1);
      bus.f_ack_i = 1; bus.f_rdata_i = 64'hBAD; bus.f_err_i = 0;
      @(posedge clk) #1;
      @(posedge clk) #1;
      bus.f_ack_i = 0; bus.f_rdata_i = 0;
      chk("late_ack_f_req", bus.f_req_o, 0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    compared = 0; failed = 0;
    rst = 1;
    bus.h_req_i = 1; bus.h_addr_i = 0; bus.c_req_i = 1; bus.c_op_i = 0; bus.c_addr_i = 0;
    bus.c_wdata_i = 0; bus.f_ack_i = 0; bus.f_rdata_i = 0; bus.f_err_i = 0;
    #12;
    chk("rst_h_gnt", bus.h_gnt_o, 0);
    chk("rst_c_gnt", bus.c_gnt_o, 0);
    chk("rst_f_req", bus.f_req_o, 0);
    chk("rst_f_cmd", {bus.f_op_o, bus.f_addr_o, bus.f_wdata_o}, 0);
    chk("rst_resp", {bus.h_rvalid_o, bus.c_done_o}, 0);
    @(negedge clk);
    rst = 0; bus.h_req_i = 0; bus.c_req_i = 0;
    @(posedge clk) #1;
    op_run(0, 2'b00, 16'h1234, 64'h0, 3, 64'hDEADBEEF_CAFEF00D, 0, 16'h1234);
    op_run(1, 2'b01, 16'h4321, 64'h01234567_89ABCDEF, 1, 64'hFFFF, 1, 16'h4321);
    op_run(1, 2'b10, 16'h8ABF, 64'h0, 2, 64'h0, 0, 16'h8A80);
    op_run(1, 2'b11, 16'h8ABF, 64'h0, 1, 64'h0, 0, 16'h8000);
    op_run(1, 2'b00, 16'h7F55, 64'h0, 4, 64'h55, 0, 16'h7F55);
    op_run(1, 2'b00, 16'h0100, 64'h0, 0, 64'h0, 0, 16'h0100);
    op_run(0, 2'b00, 16'h0001, 64'h0, 1, 64'hA5, 1, 16'h0001);
    rst = 1;
    @(posedge clk) #1;
    rst = 0;
    @(posedge clk) #1;
    bus.h_req_i = 1; bus.h_addr_i = 16'h0010; bus.c_req_i = 1; bus.c_op_i = 0; bus.c_addr_i = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_h_gnt", bus.h_gnt_o, i % 2 == 0);
      chk("alt_c_gnt", bus.c_gnt_o, i % 2 == 1);
      q.push_back('{i % 2 == 1, 64'(i + 1), 1'b0});
      @(posedge clk) #1;
      chk("no_gnt_busy", bus.h_gnt_o | bus.c_gnt_o, 0);
      bus.f_ack_i = 1; bus.f_rdata_i = 64'(i + 1);
      @(posedge clk) #1;
      bus.f_ack_i = 0; bus.f_rdata_i = 0;
      chk("no_gnt_resp", bus.h_gnt_o | bus.c_gnt_o, 0);
      @(posedge clk) #1;
    end
    bus.h_req_i = 0; bus.c_req_i = 0;
    @(posedge clk) #1;
    bus.h_req_i = 1; bus.h_addr_i = 16'h0abc;
    #1;
    chk("pre_rst_h_gnt", bus.h_gnt_o, 1);
    @(posedge clk) #1;
    bus.c_req_i = 1; bus.c_addr_i = 16'h0def;
    chk("pre_rst_f_req", bus.f_req_o, 1);
    #2 rst = 1;
    #1;
    chk("rst_busy_f_req", bus.f_req_o, 0);
    chk("rst_busy_gnt", bus.h_gnt_o | bus.c_gnt_o, 0);
    chk("rst_busy_resp", bus.h_rvalid_o | bus.c_done_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_h_gnt", bus.h_gnt_o, 1);
    chk("post_rst_c_gnt", bus.c_gnt_o, 0);
    q.push_back('{1'b0, 64'h77, 1'b0});
    @(posedge clk) #1;
    bus.h_req_i = 0; bus.c_req_i = 0;
    chk("post_rst_f_addr", bus.f_addr_o, 16'h0abc);
    bus.f_ack_i = 1; bus.f_rdata_i = 64'h77;
    @(posedge clk) #1;
    bus.f_ack_i = 0; bus.f_rdata_i = 0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/flash_bank_arb.md
FLASH_BANK_ARB -- requirements
Module: flash_bank_arb

Interface
REQ-001 SHALL have parameter DataWidth, default 64, flash word width in bits.
REQ-002 SHALL have parameter AddrWidth, default 16: bank[15] (2 banks), page[14:7] (256 pages), word[6:0] (128 words).
REQ-003 SHALL have parameter TimeoutCycles, default 255, maximum BUSY cycles before abort (range 1..255).
REQ-004 clk_i  in  1  sole clock; all state rises on posedge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 h_req_i  in  1  host read request; held until h_gnt_o.
REQ-007 h_addr_i  in  AddrWidth  host read address.
REQ-008 h_gnt_o  out  1  host request accepted (one-cycle pulse).
REQ-009 h_rvalid_o  out  1  host response valid (one-cycle pulse).
REQ-010 h_rdata_o  out  DataWidth  host read data, valid with h_rvalid_o.
REQ-011 h_err_o  out  1  host error, valid with h_rvalid_o.
REQ-012 c_req_i  in  1  controller request; held until c_gnt_o.
REQ-013 c_op_i  in  2  00 read, 01 program, 10 page erase, 11 bank erase.
REQ-014 c_addr_i  in  AddrWidth  controller address.
REQ-015 c_wdata_i  in  DataWidth  program data.
REQ-016 c_gnt_o  out  1  controller request accepted (one-cycle pulse).
REQ-017 c_done_o  out  1  controller response valid (one-cycle pulse).
REQ-018 c_rdata_o  out  DataWidth  controller read data, valid with c_done_o.
REQ-019 c_err_o  out  1  controller error, valid with c_done_o.
REQ-020 f_req_o, f_op_o[1:0], f_addr_o[AddrWidth-1:0], f_wdata_o[DataWidth-1:0]  out  flash macro command, all registered.
REQ-021 f_ack_i  in  1, f_rdata_i  in  DataWidth, f_err_i  in  1  macro completion, data, error; sampled only in BUSY.

Function
REQ-022 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; one operation outstanding at a time.
REQ-023 IDLE: any request -> assert winner's gnt combinationally that cycle, capture op/addr/wdata (host op forced 00, wdata 0), go BUSY with f_req_o=1 next cycle.
REQ-024 Only one gnt per cycle; no gnt outside IDLE; requests arriving in BUSY/RESP wait.
REQ-025 Arbitration: single requester wins; both requesting -> grant requester not granted last; last-grant pointer updates on each gnt.
REQ-026 Address shaping: page erase forces f_addr_o[6:0]=0; bank erase forces f_addr_o[14:0]=0; read/program pass address unchanged.
REQ-027 BUSY: f_req_o and command held stable until f_ack_i=1 or timeout.
REQ-028 BUSY, f_ack_i=1 -> capture f_rdata_i (0 for non-read ops) and f_err_i, drop f_req_o, go RESP.
REQ-029 8-bit timeout counter cleared on entering BUSY, +1 per BUSY cycle without ack; reaching TimeoutCycles -> drop f_req_o, go RESP with err=1, rdata=0.
REQ-030 f_ack_i in same cycle as timeout reached -> ack wins (err=f_err_i).
REQ-031 RESP: one-cycle pulse of owner's rvalid/done with captured rdata/err; other requester's response outputs 0; go IDLE.
REQ-032 rdata/err outputs 0 whenever corresponding valid/done is 0.
REQ-033 f_ack_i outside BUSY SHALL be ignored.

Reset
REQ-034 rst_i=1 SHALL immediately force IDLE, all outputs 0, timeout counter 0, last-grant=controller (host wins first tie).
REQ-035 Reset mid-operation abandons the operation: no response pulse issued, f_req_o drops asynchronously.

Verification
REQ-036 Host read 0x1234, macro ack 3 cycles after f_req_o with f_rdata_i=0xDEADBEEF_CAFEF00D -> h_gnt_o in request cycle, f_addr_o=0x1234, h_rvalid_o 1 cycle after ack with that data, h_err_o=0.
REQ-037 Both request from reset, repeatedly -> grants alternate host, ctrl, host, ctrl; never both in one cycle.
REQ-038 Ctrl page erase addr 0x8ABF -> f_op_o=10, f_addr_o=0x8A80; bank erase addr 0x8ABF -> f_op_o=11, f_addr_o=0x8000.
REQ-039 TimeoutCycles=4, no f_ack_i -> f_req_o high exactly 4 cycles, then c_done_o=1, c_err_o=1, c_rdata_o=0; late f_ack_i ignored.
REQ-040 rst_i asserted in BUSY -> f_req_o=0 immediately, no done/rvalid pulse; after release, pending host request granted first.
